// File: rtl/soc_wb_split_tmo_pkg.sv
// Shared definitions for the Wishbone splitter: FSM encodings, default error data,
// and the slave-select width helper.
package soc_wb_split_tmo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } wb_st_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
  localparam int          ERR_CNT_W    = 8;

  // A single slave still needs one select bit so the top address bit can flag decode errors.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/soc_wb_tmo_cnt.sv
// Load/decrement watchdog counter. With TMO_CYCLES == 0 it never expires.
module soc_wb_tmo_cnt #(
  parameter int TMO_W      = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = TMO_W'(TMO_CYCLES);
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (TMO_CYCLES != 0) && (cnt_q == '0);

endmodule

// File: rtl/soc_wb_split_tmo.sv
// Wishbone 1-to-WB_N splitter: one transaction in flight, registered ack, watchdog
// termination of hung slaves and sticky error capture for firmware.
module soc_wb_split_tmo
  import soc_wb_split_tmo_pkg::*;
#(
  parameter int          WB_N       = 6,
  parameter int          WB_DW      = 32,
  parameter int          WB_AW      = 16,
  parameter int          TMO_W      = 8,
  parameter int          TMO_CYCLES = 255,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WB_AW-1:0]      m_addr,
  input  logic [WB_DW-1:0]      m_wdata,
  input  logic [WB_DW/8-1:0]    m_wmsk,
  input  logic                  m_we,
  input  logic                  m_cyc,
  output logic [WB_DW-1:0]      m_rdata,
  output logic                  m_ack,
  output logic                  m_err,
  output logic [WB_AW-1:0]      wb_addr,
  output logic [WB_DW-1:0]      wb_wdata,
  output logic [WB_DW/8-1:0]    wb_wmsk,
  output logic                  wb_we,
  output logic [WB_N-1:0]       wb_cyc,
  input  logic [WB_N-1:0]       wb_ack,
  input  logic [WB_N*WB_DW-1:0] wb_rdata,
  output logic [3:0]            err_slave,
  output logic                  err_dec,
  output logic [WB_AW-1:0]      err_addr,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  input  logic                  err_clr
);

  localparam int               SW    = sel_width(WB_N);
  localparam logic [WB_DW-1:0] ERR_W = WB_DW'(ERR_DATA);

  wb_st_e                 state_q, state_d;
  logic [SW-1:0]          sel_q, sel_d;
  logic                   m_err_q, m_err_d;
  logic [WB_DW-1:0]       rdata_q, rdata_d;
  logic [3:0]             err_slave_q, err_slave_d;
  logic                   err_dec_q, err_dec_d;
  logic [WB_AW-1:0]       err_addr_q, err_addr_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [SW-1:0]                 sel_in;
  logic                          sel_ok;
  logic [WB_N-1:0]               sel_oh;
  logic [WB_N-1:0][WB_DW-1:0]    s_rdata;
  logic [WB_DW-1:0]              mux_rdata;
  logic                          ack_sel, tmo_load, tmo_dec, tmo_exp;
  logic                          err_hit, dec_err;

  assign sel_in = m_addr[WB_AW-1 -: SW];
  assign sel_ok = 32'(sel_in) < 32'(WB_N);

  for (genvar g = 0; g < WB_N; g++) begin : g_slv
    assign s_rdata[g] = wb_rdata[g*WB_DW +: WB_DW];
    assign sel_oh[g]  = (sel_q == SW'(g));
  end

  always_comb begin
    mux_rdata = '0;
    for (int i = 0; i < WB_N; i++) mux_rdata |= s_rdata[i] & {WB_DW{sel_oh[i]}};
  end

  assign ack_sel = |(wb_ack & sel_oh);

  soc_wb_tmo_cnt #(.TMO_W(TMO_W), .TMO_CYCLES(TMO_CYCLES)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .dec     (tmo_dec),
    .expired (tmo_exp)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    m_err_d  = m_err_q;
    rdata_d  = rdata_q;
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
    err_hit  = 1'b0;
    dec_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m_cyc) begin
          sel_d = sel_in;
          if (sel_ok) begin
            state_d  = ST_BUSY;
            tmo_load = 1'b1;
          end else begin
            state_d = ST_RESP;
            m_err_d = 1'b1;
            rdata_d = ERR_W;
            err_hit = 1'b1;
            dec_err = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // Ack beats expiry when both land in the same cycle.
        if (ack_sel) begin
          state_d = ST_RESP;
          m_err_d = 1'b0;
          rdata_d = m_we ? '0 : mux_rdata;
        end else if (tmo_exp) begin
          state_d = ST_RESP;
          m_err_d = 1'b1;
          rdata_d = ERR_W;
          err_hit = 1'b1;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        m_err_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_slave_d = err_slave_q;
    err_dec_d   = err_dec_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
      err_dec_d = 1'b0;
    end
    if (err_hit) begin
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + 1'b1;
      err_dec_d   = dec_err;
      err_slave_d = dec_err ? 4'(WB_N - 1) : 4'(sel_q);
      err_addr_d  = m_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      m_err_q     <= 1'b0;
      rdata_q     <= '0;
      err_slave_q <= '0;
      err_dec_q   <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      m_err_q     <= m_err_d;
      rdata_q     <= rdata_d;
      err_slave_q <= err_slave_d;
      err_dec_q   <= err_dec_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign m_ack     = (state_q == ST_RESP);
  assign m_err     = m_err_q;
  assign m_rdata   = rdata_q;
  assign wb_cyc    = (state_q == ST_BUSY) ? sel_oh : '0;
  assign wb_addr   = m_addr;
  assign wb_wdata  = m_wdata;
  assign wb_wmsk   = m_wmsk;
  assign wb_we     = m_we;
  assign err_slave = err_slave_q;
  assign err_dec   = err_dec_q;
  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule
